// File: rtl/err_expect_pkg.sv
// Shared constants, element type and the widened subtract used by err_expect_stream.
// ERR_EXPECT_SAT_EN selects clamping instead of wrap-around in sat_sub.
package err_expect_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ADDR_BITS = 6;
  localparam int DEF_LENGTH    = 64;
  localparam int MAX_WIDTH     = 64;

  // One extra bit above the widest supported element keeps every difference exact.
  typedef logic signed [MAX_WIDTH:0] wide_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 last;
  } err_elem_t;

  // a and b arrive sign-extended from a width-bit element; the result is the
  // difference reduced back into the signed width-bit range, sign-extended.
  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int width);
    wide_t diff;
    diff = a - b;
`ifdef ERR_EXPECT_SAT_EN
    begin
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (width - 1));
      if (diff > hi)      diff = hi;
      else if (diff < lo) diff = lo;
    end
`else
    diff = (diff <<< (MAX_WIDTH + 1 - width)) >>> (MAX_WIDTH + 1 - width);
`endif
    return diff;
  endfunction

endpackage

// File: rtl/memory_param.sv
// Expected-value store: synchronous read with enable, independent write port,
// read-before-write on a same-address collision.
module memory_param #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  // NOTE: storage arrays and their read register carry no reset so they map
  // onto block RAM; a reset would force a flop-based implementation.
  always_ff @(posedge clk) begin
    if (we)    mem[wr_addr] <= wr_data;
    if (rd_en) rd_data      <= mem[rd_addr];
  end

endmodule

// File: rtl/err_expect_stream.sv
// Streams (actual - expected) per element through a two-stage backpressured pipe.
// Define ERR_EXPECT_SAT_EN for clamped results; default wraps to WIDTH bits.
module err_expect_stream
  import err_expect_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int LENGTH    = DEF_LENGTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  input  logic [ADDR_BITS-1:0]    load_addr,
  input  logic [WIDTH-1:0]        load_data,
  input  logic                    restart,
  input  logic                    act_valid,
  output logic                    act_ready,
  input  logic signed [WIDTH-1:0] act_data,
  output logic                    err_valid,
  input  logic                    err_ready,
  output logic signed [WIDTH-1:0] err_data,
  output logic                    err_last
);

  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(LENGTH - 1);

  logic [ADDR_BITS-1:0]    idx;
  logic [ADDR_BITS-1:0]    use_idx;
  logic [ADDR_BITS-1:0]    next_idx;
  logic                    handshake;
  logic                    s2_free;
  logic                    s1_valid;
  logic                    s1_last;
  logic signed [WIDTH-1:0] s1_act;
  logic [WIDTH-1:0]        rd_data;

  assign s2_free   = !err_valid || err_ready;
  assign act_ready = !s1_valid || s2_free;
  assign handshake = act_valid && act_ready;

  // A restart coinciding with a handshake makes that element index 0.
  assign use_idx  = restart ? '0 : idx;
  assign next_idx = (use_idx == LAST_IDX) ? '0 : use_idx + ADDR_BITS'(1);

  // NOTE: every clocked register uses <= so all stages sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         idx <= '0;
    else if (handshake) idx <= next_idx;
    else if (restart)   idx <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_act   <= '0;
    end else if (handshake) begin
      s1_valid <= 1'b1;
      s1_last  <= (use_idx == LAST_IDX);
      s1_act   <= act_data;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // rd_data only changes on a handshake, which always coincides with s1 moving
  // on, so it stays paired with the element held in s1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_valid <= 1'b0;
      err_data  <= '0;
      err_last  <= 1'b0;
    end else if (s2_free) begin
      err_valid <= s1_valid;
      if (s1_valid) begin
        err_data <= WIDTH'(sat_sub(wide_t'(s1_act), wide_t'($signed(rd_data)), WIDTH));
        err_last <= s1_last;
      end
    end
  end

  memory_param #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk     (clk),
    .we      (load_valid),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_en   (handshake),
    .rd_addr (use_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_err_expect_stream.sv
// Scoreboard bench for err_expect_stream: directed scenarios followed by random traffic,
// expected errors computed from an array model of the store and a software vector index.
module tb_err_expect_stream;
  import err_expect_pkg::*;

  localparam int W  = 32;
  localparam int AB = 6;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [AB-1:0] load_addr = '0;
  logic [W-1:0]  load_data = '0;
  logic          restart = 1'b0;
  logic          act_valid = 1'b0;
  logic          act_ready;
  logic [W-1:0]  act_data = '0;
  logic          err_valid;
  logic          err_ready = 1'b0;
  logic [W-1:0]  err_data;
  logic          err_last;

  int n_cmp = 0;
  int n_bad = 0;

  err_elem_t  exp_q[$];
  logic [W-1:0] exp_mem [2**AB];
  int         m_idx = 0;

  err_expect_stream #(.WIDTH(W), .ADDR_BITS(AB), .LENGTH(L)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .restart(restart), .act_valid(act_valid),
    .act_ready(act_ready), .act_data(act_data), .err_valid(err_valid),
    .err_ready(err_ready), .err_data(err_data), .err_last(err_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Signed difference from plain integer arithmetic, then clamp or keep low bits.
  function automatic logic [W-1:0] model_err(input logic [W-1:0] a, input logic [W-1:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
`ifdef ERR_EXPECT_SAT_EN
    if (d > 64'sd2147483647)       d = 64'sd2147483647;
    else if (d < -64'sd2147483648) d = -64'sd2147483648;
`endif
    return d[W-1:0];
  endfunction

  // One clock: decide acceptance before the edge, update the model, land at edge+1.
  task automatic step();
    int        use_i;
    err_elem_t e;
    @(negedge clk);
    use_i = restart ? 0 : m_idx;
    if (act_valid && act_ready) begin
      e.data = model_err(act_data, exp_mem[use_i]);
      e.last = (use_i == L - 1);
      exp_q.push_back(e);
      m_idx = (use_i + 1) % L;
    end else if (restart) begin
      m_idx = 0;
    end
    if (load_valid) exp_mem[load_addr] = load_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    act_valid  = 1'b0;
    load_valid = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    err_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic send(input logic [W-1:0] v);
    act_valid = 1'b1;
    act_data  = v;
    step();
  endtask

  // Monitor: pops on every output handshake, and checks outputs hold while stalled.
  initial begin
    logic         held = 1'b0;
    logic [W-1:0] held_data = '0;
    logic         held_last = 1'b0;
    err_elem_t    e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid_hold", 64'(err_valid), 64'd1);
          check("stall_data_hold", 64'(err_data), 64'(held_data));
          check("stall_last_hold", 64'(err_last), 64'(held_last));
        end
        held      = err_valid && !err_ready;
        held_data = err_data;
        held_last = err_last;
        if (err_valid && err_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got data 0x%0h with nothing expected at %0t",
                     err_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("err_data", 64'(err_data), 64'(e.data));
            check("err_last", 64'(err_last), 64'(e.last));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d outputs outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_data", 64'(err_data), 64'd0);
    check("rst_err_last", 64'(err_last), 64'd0);
    check("rst_act_ready", 64'(act_ready), 64'd1);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // Expected vector: element i = i.
    for (int i = 0; i < L; i++) begin
      load_valid = 1'b1;
      load_addr  = AB'(i);
      load_data  = W'(i);
      step();
    end
    load_valid = 1'b0;

    // Basic vector with latency probe.
    err_ready = 1'b1;
    send(32'd10);
    check("lat_first_edge", 64'(err_valid), 64'd0);
    send(32'd20);
    check("lat_second_edge", 64'(err_valid), 64'd1);
    send(32'd30);
    send(32'd40);
    drain();

    // Backpressure: two accepts fill the pipe, then act_ready drops.
    err_ready = 1'b0;
    send(32'd100);
    check("bp_ready_after_1", 64'(act_ready), 64'd1);
    send(32'd200);
    check("bp_ready_after_2", 64'(act_ready), 64'd0);
    act_data = 32'd300;
    repeat (3) step();
    check("bp_ready_stalled", 64'(act_ready), 64'd0);
    err_ready = 1'b1;
    #1;
    check("bp_ready_return", 64'(act_ready), 64'd1);
    send(32'd300);
    send(32'd400);
    drain();

    // Wrap and restart: six elements, then restart with the seventh.
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int i = 0; i < 6; i++) send(W'(1000 + 10 * i));
    restart = 1'b1;
    send(32'd2000);
    restart = 1'b0;
    drain();

    // Read/write collision at index 0.
    restart    = 1'b1;
    load_valid = 1'b1;
    load_addr  = '0;
    load_data  = 32'd2;
    step();
    restart   = 1'b0;
    load_data = 32'd5;
    send(32'd9);
    load_valid = 1'b0;
    for (int i = 0; i < L; i++) send(W'(50 + i));
    drain();

    // Saturation / wrap extremes.
    load_valid = 1'b1;
    load_addr  = AB'(1);
    load_data  = 32'hFFFF_FFFF;
    restart    = 1'b1;
    step();
    restart   = 1'b0;
    load_addr = AB'(2);
    load_data = 32'd1;
    step();
    load_valid = 1'b0;
    send(32'd7);
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    send(32'h8000_0000);
    drain();

    // Asynchronous reset with both stages occupied.
    err_ready = 1'b0;
    send(32'd11);
    send(32'd12);
    act_valid = 1'b0;
    #2 reset = 1'b0;
    exp_q.delete();
    m_idx = 0;
    #1;
    check("arst_err_valid", 64'(err_valid), 64'd0);
    check("arst_act_ready", 64'(act_ready), 64'd1);
    check("arst_err_last", 64'(err_last), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    err_ready = 1'b1;
    send(32'd77);
    send(32'd78);
    drain();

    // Random traffic with loads, restarts and backpressure.
    for (int c = 0; c < 600; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_addr  = AB'($urandom_range(0, 5));
      load_data  = $urandom;
      restart    = ($urandom_range(0, 15) == 0);
      act_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       act_data = 32'h7FFF_FFFF;
        1:       act_data = 32'h8000_0000;
        default: act_data = $urandom;
      endcase
      err_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    idle_inputs();
    err_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
